// File: rtl/ps2_scancode_receiver.sv
//==============================================================================
// Module      : ps2_scancode_receiver
// Description : PS/2 keyboard receiver. Synchronises and filters the raw
//               PS2_CLK/PS2_DATA lines, decodes start/data/parity/stop frames
//               and assembles final scancodes with make/break (0xF0) and
//               extended (0xE0) prefix flags into a handshaked holding
//               register.
//               Optional feature macro: PS2_PARITY_CHECK_EN
//                 defined   -> odd parity enforced, oParityErr pulses on failure
//                 undefined -> parity bit captured but ignored, oParityErr = 0
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ps2_scancode_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  input  logic       iAck,
  output logic [7:0] oScanCode,
  output logic       oValid,
  output logic       oBreak,
  output logic       oExtended,
  output logic       oOverrun,
  output logic       oParityErr
);

  localparam int                TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]  TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  // Synchroniser and filter state
  logic [1:0]            r_clk_sync;
  logic [1:0]            r_dat_sync;
  logic [FILTER_LEN-1:0] r_clk_sr;
  logic [FILTER_LEN-1:0] r_dat_sr;
  logic                  r_clk_filt;
  logic                  r_dat_filt;
  logic                  r_fall;

  logic [FILTER_LEN-1:0] w_clk_sr_nxt;
  logic [FILTER_LEN-1:0] w_dat_sr_nxt;
  logic                  w_clk_filt_nxt;
  logic                  w_dat_filt_nxt;

  // Frame state
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [3:0]       r_bitcnt;
  logic [7:0]       r_shift;
  logic             r_parity;
  logic [TMO_W-1:0] r_tmo;
  logic             w_timeout;
  logic             w_start;
  logic             w_shift;
  logic             w_cap_par;
  logic             w_cap_stop;

  // Prefix and delivery
  logic       r_pend_ext;
  logic       r_pend_brk;
  logic       w_par_ok;
  logic       w_byte_good;
  logic       w_par_fail;
  logic       w_is_e0;
  logic       w_is_f0;
  logic       w_final;

  logic [7:0] r_code;
  logic       r_valid;
  logic       r_brk;
  logic       r_ext;
  logic       r_overrun;
  logic       r_parity_err;

  // Filter next values: a line moves only once the whole window agrees
  assign w_clk_sr_nxt   = {r_clk_sr[FILTER_LEN-2:0], r_clk_sync[1]};
  assign w_dat_sr_nxt   = {r_dat_sr[FILTER_LEN-2:0], r_dat_sync[1]};
  assign w_clk_filt_nxt = (&w_clk_sr_nxt) ? 1'b1 : ((~|w_clk_sr_nxt) ? 1'b0 : r_clk_filt);
  assign w_dat_filt_nxt = (&w_dat_sr_nxt) ? 1'b1 : ((~|w_dat_sr_nxt) ? 1'b0 : r_dat_filt);

  // Two-flop synchronisers, shift filters and the registered fall strobe
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_sr   <= '1;
      r_dat_sr   <= '1;
      r_clk_filt <= 1'b1;
      r_dat_filt <= 1'b1;
      r_fall     <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[0], PS2_CLK};
      r_dat_sync <= {r_dat_sync[0], PS2_DATA};
      r_clk_sr   <= w_clk_sr_nxt;
      r_dat_sr   <= w_dat_sr_nxt;
      r_clk_filt <= w_clk_filt_nxt;
      r_dat_filt <= w_dat_filt_nxt;
      r_fall     <= r_clk_filt & ~w_clk_filt_nxt;
    end
  end

  // Abort a stalled partial frame once no fall strobe arrives in time
  assign w_timeout = (r_state != S_IDLE) && !r_fall && (r_tmo == TMO_MAX);

  // Frame FSM state register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_fall && !r_dat_filt) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_timeout)                       w_state_nxt = S_IDLE;
        else if (r_fall && r_bitcnt == 4'd7) w_state_nxt = S_PARITY;
      end
      S_PARITY: begin
        if (w_timeout)   w_state_nxt = S_IDLE;
        else if (r_fall) w_state_nxt = S_STOP;
      end
      default: begin
        if (w_timeout || r_fall) w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Frame FSM output decode: which bit the current fall strobe carries
  always_comb begin
    w_start    = 1'b0;
    w_shift    = 1'b0;
    w_cap_par  = 1'b0;
    w_cap_stop = 1'b0;
    case (r_state)
      S_IDLE:   w_start    = r_fall && !r_dat_filt;
      S_DATA:   w_shift    = r_fall;
      S_PARITY: w_cap_par  = r_fall;
      default:  w_cap_stop = r_fall;
    endcase
  end

  // Bit counter, data shifter, parity capture and timeout counter
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_bitcnt <= 4'd0;
      r_shift  <= 8'h00;
      r_parity <= 1'b0;
      r_tmo    <= '0;
    end else begin
      if (w_start)        r_bitcnt <= 4'd0;
      else if (w_shift)   r_bitcnt <= r_bitcnt + 4'd1;
      if (w_shift)        r_shift  <= {r_dat_filt, r_shift[7:1]};
      if (w_cap_par)      r_parity <= r_dat_filt;
      if (r_state == S_IDLE || r_fall || w_timeout) r_tmo <= '0;
      else                                          r_tmo <= r_tmo + 1'b1;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  assign w_par_ok = ^{r_shift, r_parity};
`else
  // Parity bit is captured for completeness but never gates delivery
  assign w_par_ok = r_parity | 1'b1;
`endif

  // Stop bit must be 1; a bad stop bit discards the frame silently
  assign w_byte_good = w_cap_stop && r_dat_filt && w_par_ok;
  assign w_par_fail  = w_cap_stop && r_dat_filt && !w_par_ok;
  assign w_is_e0     = (r_shift == 8'hE0);
  assign w_is_f0     = (r_shift == 8'hF0);
  assign w_final     = w_byte_good && !w_is_e0 && !w_is_f0;

  // Prefix tracking: flags survive timeouts and parity failures
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_pend_ext <= 1'b0;
      r_pend_brk <= 1'b0;
    end else if (w_byte_good) begin
      if (w_is_e0) begin
        r_pend_ext <= 1'b1;
      end else if (w_is_f0) begin
        r_pend_brk <= 1'b1;
      end else begin
        r_pend_ext <= 1'b0;
        r_pend_brk <= 1'b0;
      end
    end
  end

  // Holding register with valid/ack handshake and sticky overrun
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_code       <= 8'h00;
      r_valid      <= 1'b0;
      r_brk        <= 1'b0;
      r_ext        <= 1'b0;
      r_overrun    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_par_fail;
      if (w_final) begin
        if (!r_valid || iAck) begin
          r_code    <= r_shift;
          r_brk     <= r_pend_brk;
          r_ext     <= r_pend_ext;
          r_valid   <= 1'b1;
          if (r_valid) r_overrun <= 1'b0;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && iAck) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end
    end
  end

  assign oScanCode  = r_code;
  assign oValid     = r_valid;
  assign oBreak     = r_brk;
  assign oExtended  = r_ext;
  assign oOverrun   = r_overrun;
  assign oParityErr = r_parity_err;

endmodule

`default_nettype wire
